// File: rtl/key_schedule_engine.sv
// rtl/key_schedule_engine.sv - iterative AES-128 key expansion sequencer (optional store: KEY_SCHED_STORE_EN)

// AES g-function: RotWord, SubWord, then Rcon folded into the leading byte.
// The S-box is computed as the GF(2^8) inverse followed by the affine map.
module G_Function (
   input  logic [7:0]  i_byte0,
   input  logic [7:0]  i_byte1,
   input  logic [7:0]  i_byte2,
   input  logic [7:0]  i_byte3,
   input  logic [3:0]  i_roundNumber,
   output logic [31:0] o_gWord
);

   logic [7:0] rcon;

   // Multiply in GF(2^8) modulo x^8+x^4+x^3+x+1.
   function automatic logic [7:0] gfMul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] prod;
      logic [7:0] acc;
      prod = 8'h00;
      acc  = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) prod = prod ^ acc;
         acc = {acc[6:0], 1'b0} ^ (acc[7] ? 8'h1b : 8'h00);
      end
      return prod;
   endfunction

   // x^254 gives the multiplicative inverse (and maps 0 to 0), then the affine step.
   function automatic logic [7:0] sBox(input logic [7:0] x);
      logic [7:0] inv;
      logic [7:0] pw;
      inv = 8'h01;
      pw  = x;
      for (int i = 1; i < 8; i++) begin
         pw  = gfMul(pw, pw);
         inv = gfMul(inv, pw);
      end
      return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                 ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
   endfunction

   // Round constant lookup; rounds outside 1..10 contribute nothing.
   always_comb begin
      rcon = 8'h00;
      case (i_roundNumber)
         4'd1:    rcon = 8'h01;
         4'd2:    rcon = 8'h02;
         4'd3:    rcon = 8'h04;
         4'd4:    rcon = 8'h08;
         4'd5:    rcon = 8'h10;
         4'd6:    rcon = 8'h20;
         4'd7:    rcon = 8'h40;
         4'd8:    rcon = 8'h80;
         4'd9:    rcon = 8'h1b;
         4'd10:   rcon = 8'h36;
         default: rcon = 8'h00;
      endcase
   end

   // Rotated word substituted byte-wise, Rcon applied to the first byte.
   always_comb begin
      o_gWord = {sBox(i_byte1) ^ rcon, sBox(i_byte2), sBox(i_byte3), sBox(i_byte0)};
   end

endmodule

// Walks round keys 0..NUM_ROUNDS out over a valid/ready handshake.
module key_schedule_engine #(
   parameter int NUM_ROUNDS = 10
) (
   input  logic         i_clk,
   input  logic         i_rst,
   input  logic         i_start,
   input  logic [127:0] i_key,
   input  logic         i_roundKeyReady,
   output logic [127:0] o_roundKey,
   output logic         o_roundKeyValid,
   output logic [3:0]   o_roundNumber,
   output logic         o_busy,
`ifdef KEY_SCHED_STORE_EN
   input  logic [3:0]   i_readRound,
   output logic [127:0] o_storedKey,
`endif
   output logic         o_done
);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] EMIT = 2'd1;
   localparam logic [1:0] DONE = 2'd2;

   localparam logic [3:0] LAST_ROUND = 4'(NUM_ROUNDS);

   logic [1:0]   state;
   logic [127:0] keyReg;
   logic [3:0]   roundCnt;
   logic [31:0]  gWord;
   logic [31:0]  n0;
   logic [31:0]  n1;
   logic [31:0]  n2;
   logic [31:0]  n3;
   logic         handshake;

   // g-word for the next round comes straight off the last word of the held key.
   G_Function gFunc (
      .i_byte0       (keyReg[31:24]),
      .i_byte1       (keyReg[23:16]),
      .i_byte2       (keyReg[15:8]),
      .i_byte3       (keyReg[7:0]),
      .i_roundNumber (roundCnt + 4'd1),
      .o_gWord       (gWord)
   );

   // Chained word XORs forming the next round key, no pipeline stage.
   always_comb begin
      n0 = keyReg[127:96] ^ gWord;
      n1 = keyReg[95:64]  ^ n0;
      n2 = keyReg[63:32]  ^ n1;
      n3 = keyReg[31:0]   ^ n2;
   end

   assign handshake       = (state == EMIT) && i_roundKeyReady;
   assign o_roundKey      = keyReg;
   assign o_roundNumber   = roundCnt;
   assign o_roundKeyValid = (state == EMIT);
   assign o_busy          = (state == EMIT);
   assign o_done          = (state == DONE);

   // Sequencer: load on start, advance one round per accepted key, pulse done once.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state    <= IDLE;
         keyReg   <= '0;
         roundCnt <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (i_start) begin
                  state    <= EMIT;
                  keyReg   <= i_key;
                  roundCnt <= 4'd0;
               end
            end
            EMIT: begin
               if (handshake) begin
                  if (roundCnt == LAST_ROUND) begin
                     state <= DONE;
                  end else begin
                     keyReg   <= {n0, n1, n2, n3};
                     roundCnt <= roundCnt + 4'd1;
                  end
               end
            end
            DONE: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

`ifdef KEY_SCHED_STORE_EN
   logic [127:0] keyStore [0:10];

   // Capture every accepted key at its round index; registered readback for decryption replay.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         for (int i = 0; i < 11; i++) keyStore[i] <= '0;
         o_storedKey <= '0;
      end else begin
         if (handshake) keyStore[roundCnt] <= keyReg;
         if (i_readRound <= 4'd10) o_storedKey <= keyStore[i_readRound];
         else                      o_storedKey <= '0;
      end
   end
`endif

endmodule

// File: tb/tb_key_schedule_engine.sv
// tb/tb_key_schedule_engine.sv - scoreboard and vector bench for key_schedule_engine
module tb_key_schedule_engine;

   logic         clk;
   logic         i_rst;
   logic         i_start;
   logic [127:0] i_key;
   logic         i_roundKeyReady;
   logic [127:0] o_roundKey;
   logic         o_roundKeyValid;
   logic [3:0]   o_roundNumber;
   logic         o_busy;
   logic         o_done;
`ifdef KEY_SCHED_STORE_EN
   logic [3:0]   i_readRound;
   logic [127:0] o_storedKey;
`endif

   key_schedule_engine dut (
      .i_clk           (clk),
      .i_rst           (i_rst),
      .i_start         (i_start),
      .i_key           (i_key),
      .i_roundKeyReady (i_roundKeyReady),
      .o_roundKey      (o_roundKey),
      .o_roundKeyValid (o_roundKeyValid),
      .o_roundNumber   (o_roundNumber),
      .o_busy          (o_busy),
`ifdef KEY_SCHED_STORE_EN
      .i_readRound     (i_readRound),
      .o_storedKey     (o_storedKey),
`endif
      .o_done          (o_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [3:0]   num;
      logic [127:0] key;
   } sb_t;

   typedef struct {
      logic [127:0] key;
      logic [127:0] exp1;
      logic [127:0] exp10;
   } vec_t;

   localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] FIPS_R1  = 128'ha0fafe1788542cb123a339392a6c7605;
   localparam logic [127:0] FIPS_R2  = 128'hf2c295f27a96b9435935807a7359f67f;
   localparam logic [127:0] FIPS_R10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

   logic [7:0] sboxTab [0:255] = '{
      8'h63,8'h7c,8'h77,8'h7b,8'hf2,8'h6b,8'h6f,8'hc5,8'h30,8'h01,8'h67,8'h2b,8'hfe,8'hd7,8'hab,8'h76,
      8'hca,8'h82,8'hc9,8'h7d,8'hfa,8'h59,8'h47,8'hf0,8'had,8'hd4,8'ha2,8'haf,8'h9c,8'ha4,8'h72,8'hc0,
      8'hb7,8'hfd,8'h93,8'h26,8'h36,8'h3f,8'hf7,8'hcc,8'h34,8'ha5,8'he5,8'hf1,8'h71,8'hd8,8'h31,8'h15,
      8'h04,8'hc7,8'h23,8'hc3,8'h18,8'h96,8'h05,8'h9a,8'h07,8'h12,8'h80,8'he2,8'heb,8'h27,8'hb2,8'h75,
      8'h09,8'h83,8'h2c,8'h1a,8'h1b,8'h6e,8'h5a,8'ha0,8'h52,8'h3b,8'hd6,8'hb3,8'h29,8'he3,8'h2f,8'h84,
      8'h53,8'hd1,8'h00,8'hed,8'h20,8'hfc,8'hb1,8'h5b,8'h6a,8'hcb,8'hbe,8'h39,8'h4a,8'h4c,8'h58,8'hcf,
      8'hd0,8'hef,8'haa,8'hfb,8'h43,8'h4d,8'h33,8'h85,8'h45,8'hf9,8'h02,8'h7f,8'h50,8'h3c,8'h9f,8'ha8,
      8'h51,8'ha3,8'h40,8'h8f,8'h92,8'h9d,8'h38,8'hf5,8'hbc,8'hb6,8'hda,8'h21,8'h10,8'hff,8'hf3,8'hd2,
      8'hcd,8'h0c,8'h13,8'hec,8'h5f,8'h97,8'h44,8'h17,8'hc4,8'ha7,8'h7e,8'h3d,8'h64,8'h5d,8'h19,8'h73,
      8'h60,8'h81,8'h4f,8'hdc,8'h22,8'h2a,8'h90,8'h88,8'h46,8'hee,8'hb8,8'h14,8'hde,8'h5e,8'h0b,8'hdb,
      8'he0,8'h32,8'h3a,8'h0a,8'h49,8'h06,8'h24,8'h5c,8'hc2,8'hd3,8'hac,8'h62,8'h91,8'h95,8'he4,8'h79,
      8'he7,8'hc8,8'h37,8'h6d,8'h8d,8'hd5,8'h4e,8'ha9,8'h6c,8'h56,8'hf4,8'hea,8'h65,8'h7a,8'hae,8'h08,
      8'hba,8'h78,8'h25,8'h2e,8'h1c,8'ha6,8'hb4,8'hc6,8'he8,8'hdd,8'h74,8'h1f,8'h4b,8'hbd,8'h8b,8'h8a,
      8'h70,8'h3e,8'hb5,8'h66,8'h48,8'h03,8'hf6,8'h0e,8'h61,8'h35,8'h57,8'hb9,8'h86,8'hc1,8'h1d,8'h9e,
      8'he1,8'hf8,8'h98,8'h11,8'h69,8'hd9,8'h8e,8'h94,8'h9b,8'h1e,8'h87,8'he9,8'hce,8'h55,8'h28,8'hdf,
      8'h8c,8'ha1,8'h89,8'h0d,8'hbf,8'he6,8'h42,8'h68,8'h41,8'h99,8'h2d,8'h0f,8'hb0,8'h54,8'hbb,8'h16
   };
   logic [7:0] rconTab [1:10] = '{8'h01,8'h02,8'h04,8'h08,8'h10,8'h20,8'h40,8'h80,8'h1b,8'h36};

   int           total = 0;
   int           bad   = 0;
   sb_t          sbQ[$];
   logic [127:0] seenKey [0:10];
   vec_t         vecs [0:1];

   // Advance one clock and settle just after the edge.
   task automatic doCycle;
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   // Reference expansion from the S-box table; pushes all 11 expected keys.
   task automatic pushModel(input logic [127:0] key);
      logic [127:0] k;
      logic [31:0]  w3;
      logic [31:0]  t;
      logic [31:0]  a;
      logic [31:0]  b;
      logic [31:0]  c;
      logic [31:0]  d;
      sb_t          e;
      k = key;
      for (int r = 0; r <= 10; r++) begin
         e.num = 4'(r);
         e.key = k;
         sbQ.push_back(e);
         if (r < 10) begin
            w3 = k[31:0];
            t  = {sboxTab[w3[23:16]] ^ rconTab[r + 1], sboxTab[w3[15:8]],
                  sboxTab[w3[7:0]], sboxTab[w3[31:24]]};
            a  = k[127:96] ^ t;
            b  = k[95:64] ^ a;
            c  = k[63:32] ^ b;
            d  = k[31:0] ^ c;
            k  = {a, b, c, d};
         end
      end
   endtask

   // One expansion with optional stall (5 cycles), start injection, or reset at a given round.
   task automatic runSeq(input logic [127:0] key, input int stallRound, input int startAt, input int rstAt);
      int  stallLeft;
      int  doneCnt;
      int  doneCyc;
      int  r10Cyc;
      int  stalls;
      bit  injected;
      sb_t e;
      for (int r = 0; r <= 10; r++) seenKey[r] = '0;
      pushModel(key);
      stallLeft = 5;
      stalls    = (stallRound >= 0) ? 5 : 0;
      doneCnt   = 0;
      doneCyc   = -1;
      r10Cyc    = -1;
      injected  = 1'b0;
      i_key     = key;
      i_start   = 1'b1;
      doCycle;
      i_start   = 1'b0;
      i_key     = {$urandom, $urandom, $urandom, $urandom};
      for (int cyc = 1; cyc <= 40; cyc++) begin
         i_roundKeyReady = 1'b1;
         i_start         = 1'b0;
         if (o_roundKeyValid && int'(o_roundNumber) == rstAt) begin
            i_rst = 1'b1;
            doCycle;
            i_rst = 1'b0;
            check("rst valid", 128'(o_roundKeyValid), 128'd0);
            check("rst busy",  128'(o_busy), 128'd0);
            check("rst done",  128'(o_done), 128'd0);
            check("rst key",   o_roundKey, 128'd0);
            check("rst round", 128'(o_roundNumber), 128'd0);
            sbQ.delete();
            for (int k = 0; k < 4; k++) begin
               doCycle;
               check("rst idle done",  128'(o_done), 128'd0);
               check("rst idle valid", 128'(o_roundKeyValid), 128'd0);
            end
            return;
         end
         if (o_roundKeyValid && int'(o_roundNumber) == startAt && !injected) begin
            i_start  = 1'b1;
            i_key    = '0;
            injected = 1'b1;
         end
         if (o_roundKeyValid && int'(o_roundNumber) == stallRound && stallLeft > 0) begin
            i_roundKeyReady = 1'b0;
            stallLeft--;
            if (sbQ.size() > 0) begin
               check("stall key",   o_roundKey, sbQ[0].key);
               check("stall round", 128'(o_roundNumber), 128'(sbQ[0].num));
            end
         end
         if (o_roundKeyValid && i_roundKeyReady) begin
            if (sbQ.size() == 0) begin
               check("sb unexpected key", 128'(o_roundNumber), 128'hffff);
            end else begin
               e = sbQ.pop_front();
               check("sb key",   o_roundKey, e.key);
               check("sb round", 128'(o_roundNumber), 128'(e.num));
               check("sb busy",  128'(o_busy), 128'd1);
               seenKey[o_roundNumber] = o_roundKey;
               if (o_roundNumber == 4'd10) r10Cyc = cyc;
            end
         end
         if (o_done) begin
            doneCnt++;
            if (doneCyc < 0) doneCyc = cyc;
         end
         doCycle;
      end
      i_start = 1'b0;
      check("round10 cycle", 128'(r10Cyc), 128'(11 + stalls));
      check("done cycle",    128'(doneCyc), 128'(12 + stalls));
      check("done pulses",   128'(doneCnt), 128'd1);
      check("sb drained",    128'(sbQ.size()), 128'd0);
   endtask

   initial begin
      vecs[0] = '{key: FIPS_KEY, exp1: FIPS_R1, exp10: FIPS_R10};
      vecs[1] = '{key: 128'd0,
                  exp1: 128'h62636363626363636263636362636363,
                  exp10: 128'hb4ef5bcb3e92e21123e951cf6f8f188e};

      i_rst           = 1'b1;
      i_start         = 1'b0;
      i_key           = '0;
      i_roundKeyReady = 1'b0;
`ifdef KEY_SCHED_STORE_EN
      i_readRound     = 4'd0;
`endif
      doCycle;
      doCycle;
      i_rst = 1'b0;
      check("reset valid", 128'(o_roundKeyValid), 128'd0);
      check("reset busy",  128'(o_busy), 128'd0);
      check("reset done",  128'(o_done), 128'd0);
      check("reset key",   o_roundKey, 128'd0);
      check("reset round", 128'(o_roundNumber), 128'd0);

      i_roundKeyReady = 1'b1;
      doCycle;
      check("ready ignored idle", 128'(o_roundKeyValid), 128'd0);

      for (int v = 0; v < 2; v++) begin
         runSeq(vecs[v].key, -1, -1, -1);
         check("vec round0",  seenKey[0],  vecs[v].key);
         check("vec round1",  seenKey[1],  vecs[v].exp1);
         check("vec round10", seenKey[10], vecs[v].exp10);
         doCycle;
      end

      runSeq(FIPS_KEY, 1, -1, -1);
      check("backpressure round1", seenKey[1], FIPS_R1);
      check("backpressure round2", seenKey[2], FIPS_R2);
      doCycle;

      runSeq(FIPS_KEY, -1, 4, -1);
      check("start in emit round10", seenKey[10], FIPS_R10);
      doCycle;

      runSeq(FIPS_KEY, -1, -1, 6);
      runSeq(FIPS_KEY, -1, -1, -1);
      check("restart round0",  seenKey[0],  FIPS_KEY);
      check("restart round10", seenKey[10], FIPS_R10);
      doCycle;

`ifdef KEY_SCHED_STORE_EN
      i_readRound = 4'd10;
      doCycle;
      check("store read10", o_storedKey, FIPS_R10);
      i_readRound = 4'd0;
      doCycle;
      check("store read0", o_storedKey, FIPS_KEY);
      i_readRound = 4'd11;
      doCycle;
      check("store read11", o_storedKey, 128'd0);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/key_schedule_engine.md
Name: key_schedule_engine

Overview:
- Iterative AES-128 key expansion sequencer.
- Sits directly downstream of G_Function and instantiates it: feeds it the last word of the current round key plus the round number, and consumes the resulting g-word to form the next round key.
- Emits round keys 0..10 one at a time over a valid/ready handshake to the round datapath.
- One 128-bit key register; one round key produced per accepted handshake.

Parameters:
- NUM_ROUNDS, 10, last round key index emitted. Fixed at 10 for AES-128; other values are unsupported.

Ports:
- i_clk  input  1  sole clock; all state updates on rising edge.
- i_rst  input  1  synchronous, active-high reset.
- i_start  input  1  start expansion; sampled only in IDLE.
- i_key  input  128  cipher key; sampled with i_start. Bits [127:96] are w0; byte [127:120] is w0 byte 0.
- i_roundKeyReady  input  1  consumer accepts o_roundKey this cycle.
- o_roundKey  output  128  current round key, same byte order as i_key.
- o_roundKeyValid  output  1  o_roundKey and o_roundNumber are valid.
- o_roundNumber  output  4  index of the presented key, 0..10.
- o_busy  output  1  high in EMIT state.
- o_done  output  1  one-cycle pulse after round 10 is accepted.

Behaviour:
- Reset:
  - i_rst synchronous, active-high; overrides every other input.
  - State returns to IDLE; key register cleared to 0; round counter cleared to 0.
  - All outputs are 0 in the cycle after reset.
  - Reset asserted mid-expansion abandons the sequence with no o_done.
- FSM states: IDLE, EMIT, DONE.
  - IDLE -> EMIT when i_start=1. i_key is loaded, round=0.
  - EMIT: o_roundKeyValid=1 and o_busy=1.
    - Handshake means o_roundKeyValid & i_roundKeyReady.
    - On a handshake with round<10: key register <= next key, round <= round+1, stay in EMIT.
    - On a handshake with round=10: go to DONE.
  - DONE: o_done=1 for exactly one cycle, then IDLE. The key register keeps its last value; o_roundKeyValid=0.
- Latency:
  - i_start at cycle t -> round 0 valid at t+1.
  - With i_roundKeyReady held high, one key per cycle: round 10 valid at t+11, o_done at t+12.
- Stability: while valid and not ready, o_roundKey and o_roundNumber are held unchanged for any number of cycles.
- Next-key arithmetic (all XORs are 32-bit):
  - Current key words are w0..w3.
  - G_Function input: bytes of w3 in order, with i_roundNumber = round+1.
  - n0 = w0 ^ g
  - n1 = w1 ^ n0
  - n2 = w2 ^ n1
  - n3 = w3 ^ n2
  - This path is combinational from the key register; no additional pipeline stage.
- Rcon is applied inside G_Function. Round numbers 1..10 map to 01,02,04,08,10,20,40,80,1B,36.
- i_start while in EMIT or DONE is ignored; i_key is not resampled.
- i_roundKeyReady while not valid is ignored.
- The round counter never exceeds 10 and never wraps to 0 while in EMIT.

Optional Feature:
- Macro: KEY_SCHED_STORE_EN.
- Defined:
  - Adds an 11 x 128 round-key store written on every handshake, indexed by o_roundNumber.
  - Adds ports i_readRound (input, 4) and o_storedKey (output, 128).
  - Read is registered: o_storedKey is valid the cycle after i_readRound is presented.
  - i_readRound > 10 returns 0.
  - Store is cleared by i_rst. Entries persist after DONE until the next i_start, which does not clear them; they are overwritten as rounds re-emit.
  - The decryption datapath uses the store for reverse-order replay.
- Undefined: the store and both ports are absent; all other behaviour is identical.

Test Plan:
- FIPS-197 key, nominal run:
  - Stimulus: reset, then i_key=2b7e151628aed2a6abf7158809cf4f3c with i_start pulse, ready held 1.
  - Required: round 0 = 2b7e1516..4f3c; round 1 = a0fafe1788542cb123a339392a6c7605; round 10 = d014f9a8c9ee2589e13f0cc8b6630ca6 at t+11; o_done pulses at t+12 for exactly 1 cycle.
- Backpressure:
  - Stimulus: same key, i_roundKeyReady low for 5 cycles while round 1 is presented.
  - Required: o_roundKey stays a0fafe17..7605 and o_roundNumber stays 1 throughout the stall; round 2 = f2c295f27a96b9435935807a7359f67f follows the accepting handshake.
- Start during EMIT:
  - Stimulus: i_start with i_key=0 asserted at round 4.
  - Required: no effect; the sequence completes with the FIPS round 10 key.
- Reset mid-run:
  - Stimulus: i_rst at round 6.
  - Required: next cycle all outputs are 0, state is IDLE, no o_done; a new i_start restarts at round 0.
- All-zero key:
  - Stimulus: i_key=0.
  - Required: round 1 = 62636363626363636263636362636363; round 10 = b4ef5bcb3e92e21123e951cf6f8f188e.
- With KEY_SCHED_STORE_EN:
  - Stimulus: after the FIPS run, i_readRound=10, then 0, then 11.
  - Required: o_storedKey = d014f9a8..0ca6, then 2b7e1516..4f3c, then 0, each one cycle after the address is presented.
